function_bist: RTL

Hardware self-test sequencer and response checker for the 4-input combinational function block, f = x3 & (x1 | x2). It drives all 16 input vectors in ascending order and waits a programmable settle time per vector. It then samples the block's output, compares it against a built-in golden model, and reports pass/fail, a mismatch count and the first failing vector. It sits beside the function block in the same clock domain and acts as the stimulus driver and checker for the block's inputs and output.

---
 rtl/function_bist_pkg.sv | 17 +
 rtl/function_bist_settle.sv | 32 +++
 rtl/function_bist.sv | 124 ++++++++++++
 3 files changed

// File: rtl/function_bist_pkg.sv
// Shared definitions for the function_bist self-test sequencer.
//   state_t  : sequencer states
//   NUM_VEC  : number of exhaustive input vectors
//   VEC_W    : width of the function block input vector
//   expected : golden model of the block under test, f = x3 & (x1 | x2)
package function_bist_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam int unsigned NUM_VEC = 16;
   localparam int unsigned VEC_W   = 4;

   function automatic logic expected(input logic [VEC_W-1:0] v);
      return v[3] & (v[1] | v[2]);
   endfunction

endpackage

// File: rtl/function_bist_settle.sv
// Per-vector settle counter for function_bist.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   load  : force the counter back to zero (priority over en)
//   en    : advance the counter by one
//   hit   : counter has reached SETTLE; the current vector is ready to sample
module function_bist_settle #(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic hit
);

   logic [3:0] cnt;

   // The counter runs 0..SETTLE, so each vector is held for SETTLE+1 cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= 4'd0;
      end else if (en) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign hit = (cnt == 4'(SETTLE));

endmodule

// File: rtl/function_bist.sv
// Self-test sequencer and response checker for the combinational block
// f = x3 & (x1 | x2). Walks all 16 vectors in ascending order, samples the
// block's response after each settle window and compares it to the golden model.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : begin a run (accepted in IDLE or DONE)
//   abort          : cancel a run; also clears done/pass when idle
//   dut_out        : response from the function block
//   vec            : drives {x3,x2,x1,x0} of the function block
//   busy, done     : run in progress / sticky run complete
//   pass           : no mismatches seen (valid with done)
//   fail_cnt       : mismatch count 0..16
//   first_fail(_vld): first mismatching vector and its valid flag
//   resp_vec       : sampled response per vector (only with FUNCTION_BIST_RESP_EN)
// Optional feature macro: FUNCTION_BIST_RESP_EN.
module function_bist
   import function_bist_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        dut_out,
   output logic [3:0]  vec,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  fail_cnt,
   output logic [3:0]  first_fail,
   output logic        first_fail_vld
`ifdef FUNCTION_BIST_RESP_EN
   ,
   output logic [15:0] resp_vec
`endif
);

   state_t     state;
   logic       hit;
   logic       mismatch;
   logic [4:0] fail_inc;

   // Counter sits at zero outside DRIVE and restarts at each vector boundary.
   function_bist_settle #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .load  ((state != DRIVE) || hit),
      .en    (state == DRIVE),
      .hit   (hit)
   );

   assign mismatch = (dut_out != expected(vec));
   assign fail_inc = fail_cnt + {4'd0, mismatch};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         vec            <= 4'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_cnt       <= 5'd0;
         first_fail     <= 4'd0;
         first_fail_vld <= 1'b0;
`ifdef FUNCTION_BIST_RESP_EN
         resp_vec       <= 16'd0;
`endif
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (abort) begin
                  state <= IDLE;
                  vec   <= 4'd0;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end else if (start) begin
                  state          <= DRIVE;
                  vec            <= 4'd0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail_cnt       <= 5'd0;
                  first_fail     <= 4'd0;
                  first_fail_vld <= 1'b0;
`ifdef FUNCTION_BIST_RESP_EN
                  resp_vec       <= 16'd0;
`endif
               end
            end
            DRIVE: begin
               // abort wins over the sample; partial results are kept.
               if (abort) begin
                  state <= IDLE;
                  vec   <= 4'd0;
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end else if (hit) begin
                  fail_cnt <= fail_inc;
                  if (mismatch && !first_fail_vld) begin
                     first_fail     <= vec;
                     first_fail_vld <= 1'b1;
                  end
`ifdef FUNCTION_BIST_RESP_EN
                  resp_vec[vec] <= dut_out;
`endif
                  if (vec == 4'(NUM_VEC - 1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (fail_inc == 5'd0);
                  end else begin
                     vec <= vec + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
